urp_pcie_rx_acknak_scheduler: RTL and testbench

- Receive-side Ack/Nak controller for the PCIe data link layer.
- Sits between the RX TLP checker (LCRC and sequence extraction) and the DLLP transmit path.
- Tracks NEXT_RCV_SEQ with modulo-4096 comparison, gates TLP forwarding, and runs the AckNak latency timer with a NAK_SCHEDULED flag.
- Owns the shared 32-bit DLLP output and drives it through a valid/read handshake.

---
 rtl/urp_pcie_dll_pkg.sv | 21 ++
 rtl/urp_pcie_acknak_timer.sv | 36 +++
 rtl/urp_pcie_rx_acknak_scheduler.sv | 130 +++++++++++++
 tb/tb_urp_pcie_rx_acknak_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/urp_pcie_dll_pkg.sv
// Shared data link layer definitions for the RX Ack/Nak scheduler: DLLP type codes,
// sequence width, output FSM encoding and modulo sequence arithmetic.
package urp_pcie_dll_pkg;

  localparam int SEQ_W = 12;

  localparam logic [7:0] DLLP_ACK = 8'h00;
  localparam logic [7:0] DLLP_NAK = 8'h10;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_e;

  // Distance of seq ahead of base, modulo 2**SEQ_W.
  function automatic logic [SEQ_W-1:0] seq_diff(input logic [SEQ_W-1:0] seq,
                                                input logic [SEQ_W-1:0] base);
    return seq - base;
  endfunction

endpackage

// File: rtl/urp_pcie_acknak_timer.sv
// AckNak latency timer: down-counter with a single-cycle expire pulse on the
// transition to zero. A running count is never restarted by another load.
module urp_pcie_acknak_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             running,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = running && !clear && (cnt == CNT_W'(1));

  // A load in the same cycle as a clear wins: that accept is not covered by the NAK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load && (!running || clear)) begin
      cnt     <= load_val;
      running <= 1'b1;
    end else if (clear) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (running) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/urp_pcie_rx_acknak_scheduler.sv
// Receive-side Ack/Nak scheduler: classifies incoming TLPs, tracks NEXT_RCV_SEQ and
// emits ACK/NAK DLLPs. Define URP_PCIE_ACKNAK_STATS_EN to add saturating statistics.
//
// state    | meaning
// OUT_IDLE | no DLLP held, waiting for an ACK or NAK request
// OUT_HOLD | DLLP held on dllp_o with dllp_valid_o high until dllp_read_i
module urp_pcie_rx_acknak_scheduler #(
  parameter int ACK_LATENCY = 32,
  parameter int SEQ_W       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tlp_evt_i,
  input  logic             tlp_lcrc_ok_i,
  input  logic [SEQ_W-1:0] tlp_seq_i,
  output logic             tlp_accept_o,
  output logic [SEQ_W-1:0] next_rcv_seq_o,
  output logic             nak_scheduled_o,
  output logic [31:0]      dllp_o,
  output logic             dllp_valid_o,
  input  logic             dllp_read_i
`ifdef URP_PCIE_ACKNAK_STATS_EN
  ,
  output logic [15:0]      stat_accept_o,
  output logic [15:0]      stat_dup_o,
  output logic [15:0]      stat_nak_o
`endif
);

  import urp_pcie_dll_pkg::*;

  localparam int TMR_W = 10;

  out_state_e       state_q, state_d;
  logic [SEQ_W-1:0] next_rcv_seq_q;
  logic [SEQ_W-1:0] diff;
  logic             nak_sched_q, ack_req_q, nak_req_q;
  logic [31:0]      dllp_q;
  logic             is_accept, is_dup, is_nak_cond, nak_set;
  logic             pending, load_dllp, load_nak;
  logic             tmr_running, tmr_expire;

  assign diff        = seq_diff(tlp_seq_i, next_rcv_seq_q);
  assign is_accept   = tlp_evt_i && tlp_lcrc_ok_i && (diff == '0);
  assign is_dup      = tlp_evt_i && tlp_lcrc_ok_i && diff[SEQ_W-1];
  assign is_nak_cond = tlp_evt_i && (!tlp_lcrc_ok_i || ((diff != '0) && !diff[SEQ_W-1]));
  assign nak_set     = is_nak_cond && !nak_sched_q;
  assign pending     = nak_req_q || ack_req_q;

  assign tlp_accept_o    = is_accept;
  assign next_rcv_seq_o  = next_rcv_seq_q;
  assign nak_scheduled_o = nak_sched_q;
  assign dllp_o          = dllp_q;

  urp_pcie_acknak_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (is_accept),
    .clear    (load_nak),
    .load_val (TMR_W'(ACK_LATENCY)),
    .running  (tmr_running),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OUT_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_IDLE: if (pending) state_d = OUT_HOLD;
      OUT_HOLD: if (dllp_read_i && !pending) state_d = OUT_IDLE;
      default:  state_d = OUT_IDLE;
    endcase
  end

  // A read with a request already pending reloads on the same edge.
  always_comb begin
    dllp_valid_o = 1'b0;
    load_dllp    = 1'b0;
    case (state_q)
      OUT_IDLE: load_dllp = pending;
      OUT_HOLD: begin
        dllp_valid_o = 1'b1;
        load_dllp    = dllp_read_i && pending;
      end
      default: ;
    endcase
    load_nak = load_dllp && nak_req_q;
  end

  // Any DLLP load retires ack_req: a NAK acknowledges everything before it too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_rcv_seq_q <= '0;
      nak_sched_q    <= 1'b0;
      ack_req_q      <= 1'b0;
      nak_req_q      <= 1'b0;
      dllp_q         <= '0;
    end else begin
      if (is_accept) next_rcv_seq_q <= next_rcv_seq_q + SEQ_W'(1);
      if (is_accept)    nak_sched_q <= 1'b0;
      else if (nak_set) nak_sched_q <= 1'b1;
      ack_req_q <= (ack_req_q && !load_dllp) || is_dup || (tmr_expire && !load_nak);
      nak_req_q <= (nak_req_q && !load_nak) || nak_set;
      if (load_dllp)
        dllp_q <= {(load_nak ? DLLP_NAK : DLLP_ACK), {(24-SEQ_W){1'b0}},
                   next_rcv_seq_q - SEQ_W'(1)};
    end
  end

`ifdef URP_PCIE_ACKNAK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_accept_o <= '0;
      stat_dup_o    <= '0;
      stat_nak_o    <= '0;
    end else begin
      if (is_accept && (stat_accept_o != 16'hFFFF)) stat_accept_o <= stat_accept_o + 16'd1;
      if (is_dup    && (stat_dup_o    != 16'hFFFF)) stat_dup_o    <= stat_dup_o + 16'd1;
      if (load_nak  && (stat_nak_o    != 16'hFFFF)) stat_nak_o    <= stat_nak_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_urp_pcie_rx_acknak_scheduler.sv
// Directed self-checking bench for the RX Ack/Nak scheduler; expected DLLPs are queued
// as stimulus is driven and compared when the DUT presents them.
module tb_urp_pcie_rx_acknak_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tlp_evt_i;
  logic        tlp_lcrc_ok_i;
  logic [11:0] tlp_seq_i;
  logic        tlp_accept_o;
  logic [11:0] next_rcv_seq_o;
  logic        nak_scheduled_o;
  logic [31:0] dllp_o;
  logic        dllp_valid_o;
  logic        dllp_read_i;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];

  urp_pcie_rx_acknak_scheduler #(
    .ACK_LATENCY (32),
    .SEQ_W       (12)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tlp_evt_i       (tlp_evt_i),
    .tlp_lcrc_ok_i   (tlp_lcrc_ok_i),
    .tlp_seq_i       (tlp_seq_i),
    .tlp_accept_o    (tlp_accept_o),
    .next_rcv_seq_o  (next_rcv_seq_o),
    .nak_scheduled_o (nak_scheduled_o),
    .dllp_o          (dllp_o),
    .dllp_valid_o    (dllp_valid_o),
    .dllp_read_i     (dllp_read_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one TLP event across the next posedge.
  task automatic send(input logic [11:0] seq, input logic ok, input logic exp_acc);
    tlp_evt_i     = 1'b1;
    tlp_seq_i     = seq;
    tlp_lcrc_ok_i = ok;
    #1;
    check("tlp_accept", 32'(tlp_accept_o), 32'(exp_acc));
    @(negedge clk);
    tlp_evt_i     = 1'b0;
    tlp_lcrc_ok_i = 1'b0;
  endtask

  task automatic wait_dllp(input string tag, input int budget);
    logic [31:0] exp;
    int n = 0;
    while (!dllp_valid_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(dllp_valid_o), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_dllp"}, dllp_o, exp);
    end
  endtask

  task automatic read_dllp();
    dllp_read_i = 1'b1;
    @(negedge clk);
    dllp_read_i = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dllp_valid_o) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; tlp_evt_i = 1'b0; tlp_lcrc_ok_i = 1'b0; tlp_seq_i = '0; dllp_read_i = 1'b0;
    do_reset();

    check("rst_next_seq", 32'(next_rcv_seq_o), 32'd0);
    check("rst_nak_sched", 32'(nak_scheduled_o), 32'd0);
    check("rst_dllp", dllp_o, 32'd0);
    check("rst_valid", 32'(dllp_valid_o), 32'd0);

    // In-order burst: one coalesced ACK 33 clocks after the first accept.
    send(12'd0, 1'b1, 1'b1);
    c0 = cyc;
    send(12'd1, 1'b1, 1'b1);
    send(12'd2, 1'b1, 1'b1);
    exp_q.push_back(32'h0000_0002);
    wait_dllp("ack_inorder", 60);
    check("ack_latency", 32'(cyc - c0), 32'd33);
    read_dllp();
    expect_quiet("single_ack", 40);

    send(12'd3, 1'b1, 1'b1);
    send(12'd4, 1'b1, 1'b1);
    exp_q.push_back(32'h0000_0004);
    wait_dllp("ack_to5", 60);
    read_dllp();
    check("next_seq_5", 32'(next_rcv_seq_o), 32'd5);

    // Lost TLPs: a single NAK, the repeat is absorbed by NAK_SCHEDULED.
    send(12'd7, 1'b1, 1'b0);
    exp_q.push_back(32'h1000_0004);
    send(12'd8, 1'b1, 1'b0);
    wait_dllp("nak_future", 10);
    check("nak_sched_set", 32'(nak_scheduled_o), 32'd1);
    read_dllp();
    expect_quiet("single_nak", 10);

    // Duplicate: immediate ACK two edges after the event.
    send(12'd3, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_0004);
    check("dup_not_yet", 32'(dllp_valid_o), 32'd0);
    @(negedge clk);
    check("dup_valid_n1", 32'(dllp_valid_o), 32'd1);
    wait_dllp("ack_dup", 2);
    read_dllp();

    send(12'd5, 1'b1, 1'b1);
    check("nak_sched_clr", 32'(nak_scheduled_o), 32'd0);
    check("next_seq_6", 32'(next_rcv_seq_o), 32'd6);
    exp_q.push_back(32'h0000_0005);
    wait_dllp("ack_after_nak", 60);
    read_dllp();

    // Bad LCRC straight out of reset, held unread for 10 clocks.
    do_reset();
    send(12'd0, 1'b0, 1'b0);
    exp_q.push_back(32'h1000_0FFF);
    wait_dllp("nak_lcrc", 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_dllp", dllp_o, 32'h1000_0FFF);
      check("hold_valid", 32'(dllp_valid_o), 32'd1);
    end
    read_dllp();
    check("released", 32'(dllp_valid_o), 32'd0);

    // Walk NEXT_RCV_SEQ up to 4095 with the consumer always ready.
    do_reset();
    dllp_read_i = 1'b1;
    for (int i = 0; i < 4095; i++) send(12'(i), 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    dllp_read_i = 1'b0;
    @(negedge clk);
    check("seq_4095", 32'(next_rcv_seq_o), 32'd4095);
    check("drained", 32'(dllp_valid_o), 32'd0);
    send(12'd4095, 1'b1, 1'b1);
    check("wrap_seq", 32'(next_rcv_seq_o), 32'd0);
    exp_q.push_back(32'h0000_0FFF);
    wait_dllp("ack_wrap", 60);
    read_dllp();
    send(12'd0, 1'b1, 1'b1);
    check("after_wrap", 32'(next_rcv_seq_o), 32'd1);
    exp_q.push_back(32'h0000_0000);
    wait_dllp("ack_seq0", 60);

    // Reset while holding with an ACK request pending.
    send(12'd0, 1'b1, 1'b0);
    check("hold_pending", 32'(dllp_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(dllp_valid_o), 32'd0);
    check("async_dllp", dllp_o, 32'd0);
    check("async_seq", 32'(next_rcv_seq_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    dllp_read_i = 1'b1;
    expect_quiet("post_reset_quiet", 50);
    dllp_read_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
